// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: synchroniser, debounce filter, edge pulses
// and a per-channel auto-repeat generator for held keys.
module btn_debounce #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned REPEAT_DELAY    = 12500000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] btn_in,
   input  logic [WIDTH-1:0] rpt_en,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release,
   output logic [WIDTH-1:0] btn_repeat
);

   localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RR_LAST = RCNT_W'(REPEAT_RATE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DELAY = 2'd1;
   localparam logic [1:0] ST_RPT   = 2'd2;

   logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]  sync;

   logic [CNT_W-1:0]  cnt_q  [WIDTH];
   logic [CNT_W-1:0]  cnt_d  [WIDTH];
   logic [RCNT_W-1:0] rcnt_q [WIDTH];
   logic [RCNT_W-1:0] rcnt_d [WIDTH];
   logic [1:0]        state_q [WIDTH];
   logic [1:0]        state_d [WIDTH];

   logic [WIDTH-1:0]  level_q, level_d;
   logic [WIDTH-1:0]  press_q, press_d;
   logic [WIDTH-1:0]  release_q, release_d;
   logic [WIDTH-1:0]  repeat_q, repeat_d;

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      repeat_d  = '0;
      cnt_d     = cnt_q;
      rcnt_d    = rcnt_q;
      state_d   = state_q;

      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (sync[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DB_LAST) begin
            level_d[i]   = sync[i];
            cnt_d[i]     = '0;
            press_d[i]   = sync[i];
            release_d[i] = ~sync[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end

         // A falling level or dropped enable wins over a due repeat pulse.
         case (state_q[i])
            ST_IDLE: begin
               if (press_d[i]) begin
                  repeat_d[i] = 1'b1;
                  if (rpt_en[i]) begin
                     state_d[i] = ST_DELAY;
                     rcnt_d[i]  = '0;
                  end
               end
            end
            ST_DELAY, ST_RPT: begin
               if (!level_d[i] || !rpt_en[i]) begin
                  state_d[i] = ST_IDLE;
                  rcnt_d[i]  = '0;
               end else if (rcnt_q[i] == ((state_q[i] == ST_DELAY) ? RD_LAST : RR_LAST)) begin
                  repeat_d[i] = 1'b1;
                  rcnt_d[i]   = '0;
                  state_d[i]  = ST_RPT;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               rcnt_d[i]  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i]   <= '0;
            rcnt_q[i]  <= '0;
            state_q[i] <= ST_IDLE;
         end
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         repeat_q  <= '0;
      end else begin
         sync_q[0] <= btn_in;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         cnt_q     <= cnt_d;
         rcnt_q    <= rcnt_d;
         state_q   <= state_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: expected per-cycle outputs are queued when
// stimulus is applied and checked as the clock advances.
module tb_btn_debounce;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn_in;
   logic [3:0] rpt_en;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [3:0] btn_repeat;

   typedef struct packed {
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] rpt;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] lv;
   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;

   btn_debounce #(
      .WIDTH           (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (6),
      .REPEAT_RATE     (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .rpt_en      (rpt_en),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] r, input logic [3:0] t);
      exp_t x;
      x.lvl = l;
      x.prs = p;
      x.rel = r;
      x.rpt = t;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (sb.size() > 0) begin
         @(posedge clk);
         #1;
         cyc++;
         x = sb.pop_front();
         chk("level",   btn_level,   x.lvl);
         chk("press",   btn_press,   x.prs);
         chk("release", btn_release, x.rel);
         chk("repeat",  btn_repeat,  x.rpt);
      end
   endtask

   function automatic bit rpt_at(int e, bit en);
      return (e == 6) || (en && e >= 12 && ((e - 12) % 3) == 0);
   endfunction

   // Press on channel ch, held for h edges counted from the input change.
   task automatic expect_press(input int ch, input int h, input bit en);
      logic [3:0] b;
      b = 4'b0001 << ch;
      for (int e = 1; e <= h; e++) begin
         push((e >= 6) ? (lv | b) : lv,
              (e == 6) ? b : 4'b0000,
              4'b0000,
              rpt_at(e, en) ? b : 4'b0000);
      end
      if (h >= 6) lv = lv | b;
   endtask

   // Release on channel ch after it was held h edges; en = repeats still live.
   task automatic expect_release(input int ch, input int h, input bit en, input int n);
      logic [3:0] b;
      b = 4'b0001 << ch;
      for (int r = 1; r <= n; r++) begin
         push((r < 6) ? lv : (lv & ~b),
              4'b0000,
              (r == 6) ? b : 4'b0000,
              (r < 6 && rpt_at(h + r, en)) ? b : 4'b0000);
      end
      if (n >= 6) lv = lv & ~b;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},   btn_level,   4'b0000);
      chk({tag, "_press"},   btn_press,   4'b0000);
      chk({tag, "_release"}, btn_release, 4'b0000);
      chk({tag, "_repeat"},  btn_repeat,  4'b0000);
   endtask

   initial begin
      rst_n  = 1'b0;
      btn_in = 4'b0000;
      rpt_en = 4'b0000;
      lv     = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) push(lv, 4'b0000, 4'b0000, 4'b0000);
      drain();

      // Case 1: channel 0 press, no auto-repeat.
      btn_in[0] = 1'b1;
      expect_press(0, 16, 1'b0);
      drain();

      // Case 2: channel 1 bounces without ever settling, then holds high.
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 3; j++) begin
            btn_in[1] = 1'b1;
            push(lv, 4'b0000, 4'b0000, 4'b0000);
            drain();
         end
         btn_in[1] = 1'b0;
         push(lv, 4'b0000, 4'b0000, 4'b0000);
         drain();
      end
      btn_in[1] = 1'b1;
      expect_press(1, 10, 1'b0);
      drain();

      // Case 3: channel 2 held 30 cycles with repeat enabled.
      btn_in[2] = 1'b1;
      rpt_en[2] = 1'b1;
      expect_press(2, 30, 1'b1);
      drain();

      // Case 4: release; repeats continue until the debounced fall, then stop.
      btn_in[2] = 1'b0;
      expect_release(2, 30, 1'b1, 10);
      drain();

      // Case 5: repeat enable dropped before edge 13, re-raised while held.
      btn_in[2] = 1'b1;
      expect_press(2, 12, 1'b1);
      drain();
      rpt_en[2] = 1'b0;
      for (int k = 0; k < 8; k++) push(lv, 4'b0000, 4'b0000, 4'b0000);
      drain();
      rpt_en[2] = 1'b1;
      for (int k = 0; k < 15; k++) push(lv, 4'b0000, 4'b0000, 4'b0000);
      drain();
      btn_in[2] = 1'b0;
      expect_release(2, 35, 1'b0, 10);
      drain();
      btn_in[2] = 1'b1;
      expect_press(2, 12, 1'b1);
      drain();
      btn_in[2] = 1'b0;
      rpt_en[2] = 1'b0;
      expect_release(2, 12, 1'b0, 10);
      drain();

      // Case 6: channel 3 pressed, then reset asserted before edge 14.
      btn_in[3] = 1'b1;
      expect_press(3, 13, 1'b0);
      drain();
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("held_reset");
      rst_n = 1'b1;
      lv    = 4'b0000;
      for (int r = 1; r <= 14; r++) begin
         push((r >= 6) ? 4'b1011 : 4'b0000,
              (r == 6) ? 4'b1011 : 4'b0000,
              4'b0000,
              (r == 6) ? 4'b1011 : 4'b0000);
      end
      drain();
      lv     = 4'b1011;
      btn_in = 4'b0000;
      for (int r = 1; r <= 8; r++) begin
         push((r < 6) ? lv : 4'b0000,
              4'b0000,
              (r == 6) ? 4'b1011 : 4'b0000,
              4'b0000);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
